// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX operand build and pipeline register; define FWD_EN to enable operand forwarding
module id_ex_operand_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic          fwd_mem_valid,
    input  logic [RW-1:0] fwd_mem_reg,
    input  logic [DW-1:0] fwd_mem_data,
    input  logic          fwd_mem_is_load,
    input  logic          fwd_wb_valid,
    input  logic [RW-1:0] fwd_wb_reg,
    input  logic [DW-1:0] fwd_wb_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    opcode,
    output logic [1:0]    funct,
    output logic [DW-1:0] Ain,
    output logic [DW-1:0] Bin,
    output logic [RW-1:0] rd
);

    logic [4:0]    op_in;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic          is_imm5;
    logic          is_shift;
    logic          is_rr;
    logic          rs_mem_hit;
    logic          rt_mem_hit;
    logic          rs_wb_hit;
    logic          rt_wb_hit;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] a_next;
    logic [DW-1:0] b_next;
    logic [RW-1:0] rd_next;
    logic          hazard;
    logic          capture;

    assign op_in    = instr[15:11];
    assign rs_idx   = instr[8 +: RW];
    assign rt_idx   = instr[5 +: RW];
    assign is_imm5  = (op_in[4:2] == 3'b010);
    assign is_shift = (op_in[4:2] == 3'b101);
    assign is_rr    = (op_in[4:1] == 4'b1101);

    // Rt only counts as a source for the register-register class
    assign rs_mem_hit = fwd_mem_valid && (fwd_mem_reg == rs_idx);
    assign rt_mem_hit = fwd_mem_valid && is_rr && (fwd_mem_reg == rt_idx);
    assign rs_wb_hit  = fwd_wb_valid && (fwd_wb_reg == rs_idx);
    assign rt_wb_hit  = fwd_wb_valid && is_rr && (fwd_wb_reg == rt_idx);

`ifdef FWD_EN
    // Source selection with bypass: MEM result beats WB, loads in MEM cannot bypass yet
    always_comb begin
        rs_val = rs_data;
        rt_val = rt_data;
        if (rs_mem_hit && !fwd_mem_is_load) begin
            rs_val = fwd_mem_data;
        end else if (rs_wb_hit) begin
            rs_val = fwd_wb_data;
        end
        if (rt_mem_hit && !fwd_mem_is_load) begin
            rt_val = fwd_mem_data;
        end else if (rt_wb_hit) begin
            rt_val = fwd_wb_data;
        end
    end

    // Only a load sitting in MEM that feeds a source forces a stall
    assign hazard = in_valid && fwd_mem_is_load && (rs_mem_hit || rt_mem_hit);
`else
    logic unused_fwd;

    // Without bypass paths the register file values are used as read
    always_comb begin
        rs_val = rs_data;
        rt_val = rt_data;
    end

    // Any in-flight writer of a source must retire before this instruction issues
    assign hazard     = in_valid && (rs_mem_hit || rt_mem_hit || rs_wb_hit || rt_wb_hit);
    assign unused_fwd = ^{fwd_mem_data, fwd_wb_data, fwd_mem_is_load};
`endif

    // Operand B and destination depend on the opcode class; unknown classes get zeros
    always_comb begin
        a_next  = rs_val;
        b_next  = '0;
        rd_next = '0;
        if (is_imm5) begin
            if (op_in[1]) begin
                b_next = {{(DW-5){1'b0}}, instr[4:0]};
            end else begin
                b_next = {{(DW-5){instr[4]}}, instr[4:0]};
            end
            rd_next = instr[5 +: RW];
        end else if (is_shift) begin
            b_next  = {{(DW-4){1'b0}}, instr[3:0]};
            rd_next = instr[5 +: RW];
        end else if (is_rr) begin
            b_next  = rt_val;
            rd_next = instr[2 +: RW];
        end
    end

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign capture  = in_valid && in_ready;

    // ID/EX register: flush beats capture, capture beats drain, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            opcode    <= '0;
            funct     <= '0;
            Ain       <= '0;
            Bin       <= '0;
            rd        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            opcode    <= op_in;
            funct     <= instr[1:0];
            Ain       <= a_next;
            Bin       <= b_next;
            rd        <= rd_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Pipeline stage directly upstream of the 16-bit ALU.
- Takes one decoded-register-read instruction per handshake and extracts opcode and funct.
- Builds the ALU operands:
  - Ain: Rs, after forwarding.
  - Bin: Rt after forwarding, or the extended immediate.
- Registers the result into a single-entry ID/EX register with valid/ready flow control.
- Detects load-use hazards, inserts bubbles, and supports flush on branch redirect.

Parameters:
- DW, 16, datapath width (Rs/Rt data, Ain, Bin, forwarded data).
- RW, 3, register index width.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; asynchronous and active-high.
- in_valid, input, 1, upstream instruction valid.
- in_ready, output, 1, stage can accept this cycle.
- instr, input, 16, instruction word.
- rs_data, input, DW, register file read of instr[10:8].
- rt_data, input, DW, register file read of instr[7:5].
- fwd_mem_valid, input, 1, EX/MEM stage writes a register.
- fwd_mem_reg, input, RW, EX/MEM destination.
- fwd_mem_data, input, DW, EX/MEM ALU result.
- fwd_mem_is_load, input, 1, EX/MEM instruction is a load (data not yet available).
- fwd_wb_valid, input, 1, MEM/WB stage writes a register.
- fwd_wb_reg, input, RW, MEM/WB destination.
- fwd_wb_data, input, DW, MEM/WB writeback data.
- flush, input, 1, synchronous squash of stage contents and of the incoming instruction.
- out_valid, output, 1, ALU operands valid.
- out_ready, input, 1, downstream accepts.
- opcode, output, 5, registered instr[15:11].
- funct, output, 2, registered instr[1:0].
- Ain, output, DW, registered A operand.
- Bin, output, DW, registered B operand.
- rd, output, RW, registered destination index.

Behaviour:
- Reset (async, rst=1): out_valid, opcode, funct, Ain, Bin and rd all 0.
- Decode fields: Rs = instr[10:8], Rt = instr[7:5].
- Per opcode class:
  - 010xx (ADDI, SUBI, XORI, ANDNI):
    - Ain = Rs; Bin = imm5 = instr[4:0].
    - Sign-extend imm5 for 01000 and 01001; zero-extend for 01010 and 01011.
    - rd = instr[7:5]; Rt is not a source.
  - 101xx (imm shifts/rotates): Ain = Rs; Bin = zero-extended instr[3:0]; rd = instr[7:5].
  - 11010 and 11011 (register shift and arithmetic): Ain = Rs; Bin = Rt; rd = instr[4:2]; funct is passed through.
  - Any other opcode: Ain = Rs; Bin = 0; rd = 0. The stage does not classify further.
- Forwarding per source (Rs always; Rt only for 1101x):
  - If fwd_mem_valid, !fwd_mem_is_load and the register matches, use fwd_mem_data.
  - Else if fwd_wb_valid and the register matches, use fwd_wb_data.
  - Else use the register file data.
  - MEM has priority over WB. Register 0 is an ordinary register.
- Hazard: in_valid && fwd_mem_valid && fwd_mem_is_load && fwd_mem_reg equals a used source.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Capture: when in_valid && in_ready, the stage registers opcode, funct, Ain, Bin and rd, and sets out_valid=1 next cycle.
- Drain:
  - If out_valid && out_ready and no capture, out_valid goes to 0 next cycle (bubble).
  - During a hazard the current entry drains normally, so exactly one bubble reaches the ALU per load-use cycle.
- Stall: if out_valid && !out_ready, all outputs hold stable. This holds regardless of in_valid and of forwarding changes.
- flush=1: out_valid goes to 0 next cycle and the incoming instruction is dropped. Flush overrides capture and stall. Data registers may keep stale values.
- Latency: 1 cycle from accepted instruction to out_valid. Throughput is 1 per cycle with no hazard.
- rst asserted mid-stall clears immediately; the first cycle after release accepts normally.

Optional Feature:
- FWD_EN defined: forwarding as above; only load-use hazards stall.
- FWD_EN undefined:
  - No forwarding; Ain and Bin take rs_data and rt_data directly.
  - The hazard condition widens to any used-source match with a valid EX/MEM or MEM/WB destination, load or not.
  - The fwd_*_data inputs are ignored.

Test Plan:
- ADDI: instr=0x4145 (op 01000, Rs=1, imm=5), rs_data=2 → next cycle out_valid=1, opcode=01000, Ain=2, Bin=0x0005, rd=2.
- SUBI with imm=0x1F → Bin=0xFFFF. ANDNI with imm=0x1F → Bin=0x001F.
- R-format 11011, funct=01, Rs=1, Rt=2, rd field=3; fwd_mem_valid=1, reg=2, data=0x0030; fwd_wb reg=2, data=0x0099 → Bin=0x0030 (MEM wins), rd=3, funct=01.
- Load-use: fwd_mem_is_load=1, fwd_mem_reg=1, incoming Rs=1 → in_ready=0 for that cycle and out_valid=0 next cycle. Once the load clears, the instruction is accepted with forwarded WB data.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0. Release → next instruction captured the following cycle, no loss or duplication.
- flush asserted while out_valid=1 and in_valid=1 → out_valid=0 next cycle and the incoming instruction is not captured. rst pulse mid-stall → all outputs 0 asynchronously.
